key_expand_ctrl: RTL and testbench

- Sequencer for AES-128 key expansion. It time-shares one external subWord unit (4 S-boxes) to generate round keys 0..10 one per handshake.
- Sits between the key input register and the round-key store/cipher core. It drives the subWord input and consumes its output.
- One subWord evaluation is needed per round (on RotWord(w[i-1]) for i mod 4 == 0). The other three words of each round are an XOR chain.

---
 rtl/key_expand_if.sv | 38 +++
 rtl/key_expand_ctrl.sv | 123 ++++++++++++
 tb/tb_key_expand_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_expand_if.sv
`default_nettype none
// ============================================================================
// Module   : key_expand_if
// Purpose  : Handshake and subWord bus between the AES-128 key expansion
//            sequencer and its environment (key source, round-key consumer,
//            and the shared external subWord unit).
// Signals  : start/key      - expansion request and cipher key
//            busy/done      - sequencer status, done is a one-cycle pulse
//            rk_valid/ready - round-key handshake
//            rk_data/round  - current round key and its index 0..10
//            sw_in/sw_out   - subWord operand and result
// Modports : slave  - the sequencer
//            master - the environment around it
// Revision : 1.0 - initial release
// ============================================================================
interface key_expand_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;
    logic [31:0]  sw_in;
    logic [31:0]  sw_out;

    modport slave (
        input  start, key, rk_ready, sw_out,
        output busy, rk_valid, rk_data, rk_round, done, sw_in
    );

    modport master (
        output start, key, rk_ready, sw_out,
        input  busy, rk_valid, rk_data, rk_round, done, sw_in
    );
endinterface
`default_nettype wire

// File: rtl/key_expand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_expand_ctrl
// Purpose  : AES-128 key expansion sequencer. Presents round keys 0..10 one
//            per rk_valid/rk_ready handshake, time-sharing one external
//            subWord unit (4 S-boxes) per round.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - key_expand_if.slave (start/key in, busy/done status,
//                     round-key handshake, subWord operand/result)
// Params   : SW_REG - subWord result latency, 0 (combinational) or 1
//            (registered externally, adds a SUB cycle per round)
// Revision : 1.0 - initial release
// ============================================================================
module key_expand_ctrl #(
    parameter int SW_REG = 0
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    key_expand_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_SUB     = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_ROUND = 4'd10;

    state_t       state_q;
    logic [127:0] rk_data_q;
    logic [3:0]   rk_round_q;
    logic [7:0]   rcon_q;
    logic         rk_valid_q;
    logic         busy_q;
    logic         done_q;

    logic [31:0]  t_d;
    logic [31:0]  w0_d, w1_d, w2_d, w3_d;
    logic [127:0] rk_data_d;
    logic [7:0]   rcon_d;

    // The subWord operand always tracks the key register, so in SUB the
    // externally registered result belongs to the key still held here.
    assign bus.sw_in = {rk_data_q[23:0], rk_data_q[31:24]};

    // Next round key: one S-box word, then a running XOR chain.
    always_comb begin
        t_d       = bus.sw_out ^ {rcon_q, 24'h0};
        w0_d      = rk_data_q[127:96] ^ t_d;
        w1_d      = rk_data_q[95:64]  ^ w0_d;
        w2_d      = rk_data_q[63:32]  ^ w1_d;
        w3_d      = rk_data_q[31:0]   ^ w2_d;
        rk_data_d = {w0_d, w1_d, w2_d, w3_d};
        rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rk_data_q  <= 128'h0;
            rk_round_q <= 4'd0;
            rcon_q     <= 8'h01;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        rk_data_q  <= bus.key;
                        rk_round_q <= 4'd0;
                        rcon_q     <= 8'h01;
                        rk_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // rk_valid is always high here, so rk_ready alone marks
                    // the handshake.
                    if (bus.rk_ready) begin
                        if (rk_round_q == C_LAST_ROUND) begin
                            rk_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_IDLE;
                        end else if (SW_REG == 0) begin
                            rk_data_q  <= rk_data_d;
                            rk_round_q <= rk_round_q + 4'd1;
                            rcon_q     <= rcon_d;
                        end else begin
                            rk_valid_q <= 1'b0;
                            state_q    <= S_SUB;
                        end
                    end
                end
                S_SUB: begin
                    rk_data_q  <= rk_data_d;
                    rk_round_q <= rk_round_q + 4'd1;
                    rcon_q     <= rcon_d;
                    rk_valid_q <= 1'b1;
                    state_q    <= S_PRESENT;
                end
                default: begin
                    rk_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_data  = rk_data_q;
    assign bus.rk_round = rk_round_q;
    assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_key_expand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_expand_ctrl
// Purpose  : Directed self-checking bench for key_expand_ctrl. Two instances
//            (SW_REG=0 and SW_REG=1) share clock and reset; the bench models
//            the external subWord unit for each.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_expand_ctrl;

    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] C_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] C_ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [127:0] fips_rk [0:10];
    logic [31:0]  sw1_q;

    key_expand_if if0 ();
    key_expand_if if1 ();

    key_expand_ctrl #(.SW_REG(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    key_expand_ctrl #(.SW_REG(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        int idx;
        idx = int'(b);
        return C_SBOX[2047 - 8*idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    // External subWord units: combinational for instance 0, registered for 1.
    assign if0.sw_out = sub_word(if0.sw_in);
    always @(posedge clk) sw1_q <= sub_word(if1.sw_in);
    assign if1.sw_out = sw1_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start0(input logic [127:0] k);
        if0.key   = k;
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fips_rk[0]  = C_FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        if0.start = 1'b0; if0.key = '0; if0.rk_ready = 1'b0;
        if1.start = 1'b0; if1.key = '0; if1.rk_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy0",  {127'h0, if0.busy},     128'h0);
        chk("rst_valid0", {127'h0, if0.rk_valid}, 128'h0);
        chk("rst_data0",  if0.rk_data,            128'h0);
        chk("rst_round0", {124'h0, if0.rk_round}, 128'h0);
        chk("rst_done0",  {127'h0, if0.done},     128'h0);
        chk("rst_sw_in0", {96'h0, if0.sw_in},     128'h0);
        chk("rst_valid1", {127'h0, if1.rk_valid}, 128'h0);
        chk("rst_busy1",  {127'h0, if1.busy},     128'h0);
        rst_n = 1'b1;
        step();
        chk("idle_valid0", {127'h0, if0.rk_valid}, 128'h0);

        // FIPS-197 key, back-to-back acceptance.
        if0.rk_ready = 1'b1;
        start0(C_FIPS_KEY);
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("a_valid_r%0d", r), {127'h0, if0.rk_valid}, {127'h0, 1'b1});
            chk($sformatf("a_round_r%0d", r), {124'h0, if0.rk_round}, 128'(r));
            chk($sformatf("a_data_r%0d", r),  if0.rk_data, fips_rk[r]);
            chk($sformatf("a_done_r%0d", r),  {127'h0, if0.done}, 128'h0);
            if (r == 0)
                chk("a_sw_in_r0", {96'h0, if0.sw_in}, {96'h0, 32'hcf4f3c09});
            step();
        end
        chk("a_done",  {127'h0, if0.done},     {127'h0, 1'b1});
        chk("a_busy",  {127'h0, if0.busy},     128'h0);
        chk("a_valid", {127'h0, if0.rk_valid}, 128'h0);

        // Start during the done cycle is accepted; all-zero key.
        start0(128'h0);
        chk("z_done_end", {127'h0, if0.done},     128'h0);
        chk("z_valid",    {127'h0, if0.rk_valid}, {127'h0, 1'b1});
        chk("z_data_r0",  if0.rk_data,            128'h0);
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("z_round_r%0d", r), {124'h0, if0.rk_round}, 128'(r));
            if (r == 1)  chk("z_data_r1",  if0.rk_data, C_ZERO_R1);
            if (r == 10) chk("z_data_r10", if0.rk_data, C_ZERO_R10);
            step();
        end
        chk("z_done", {127'h0, if0.done}, {127'h0, 1'b1});
        step();
        chk("z_done_pulse", {127'h0, if0.done}, 128'h0);
        chk("z_busy",       {127'h0, if0.busy}, 128'h0);

        // Stall at round 3, ignored start with another key at round 5.
        start0(C_FIPS_KEY);
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("b_data_r%0d", r),  if0.rk_data, fips_rk[r]);
            chk($sformatf("b_round_r%0d", r), {124'h0, if0.rk_round}, 128'(r));
            if (r == 3) begin
                if0.rk_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk($sformatf("b_stall_data%0d", s),  if0.rk_data, fips_rk[3]);
                    chk($sformatf("b_stall_round%0d", s), {124'h0, if0.rk_round}, 128'd3);
                    chk($sformatf("b_stall_valid%0d", s), {127'h0, if0.rk_valid}, {127'h0, 1'b1});
                    chk($sformatf("b_stall_busy%0d", s),  {127'h0, if0.busy}, {127'h0, 1'b1});
                end
                if0.rk_ready = 1'b1;
            end
            if (r == 5) begin
                if0.start = 1'b1;
                if0.key   = ~C_FIPS_KEY;
            end
            step();
            if0.start = 1'b0;
        end
        chk("b_done", {127'h0, if0.done}, {127'h0, 1'b1});
        step();

        // Asynchronous reset at round 7, then a fresh expansion.
        start0(C_FIPS_KEY);
        for (int r = 0; r < 7; r++) step();
        chk("c_round7", {124'h0, if0.rk_round}, 128'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c_rst_busy",  {127'h0, if0.busy},     128'h0);
        chk("c_rst_valid", {127'h0, if0.rk_valid}, 128'h0);
        chk("c_rst_data",  if0.rk_data,            128'h0);
        step();
        chk("c_rst_done", {127'h0, if0.done}, 128'h0);
        rst_n = 1'b1;
        step();
        chk("c_idle_done", {127'h0, if0.done}, 128'h0);
        start0(C_FIPS_KEY);
        chk("c_data_r0", if0.rk_data, fips_rk[0]);
        step();
        chk("c_data_r1",  if0.rk_data, fips_rk[1]);
        chk("c_round_r1", {124'h0, if0.rk_round}, 128'd1);
        if0.rk_ready = 1'b0;
        step();

        // Registered subWord: one key per two cycles.
        if1.rk_ready = 1'b1;
        if1.key      = C_FIPS_KEY;
        if1.start    = 1'b1;
        step();
        if1.start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("d_valid_r%0d", r), {127'h0, if1.rk_valid}, {127'h0, 1'b1});
            chk($sformatf("d_round_r%0d", r), {124'h0, if1.rk_round}, 128'(r));
            chk($sformatf("d_data_r%0d", r),  if1.rk_data, fips_rk[r]);
            step();
            if (r < 10) begin
                chk($sformatf("d_sub_valid_r%0d", r), {127'h0, if1.rk_valid}, 128'h0);
                chk($sformatf("d_sub_data_r%0d", r),  if1.rk_data, fips_rk[r]);
                chk($sformatf("d_sub_busy_r%0d", r),  {127'h0, if1.busy}, {127'h0, 1'b1});
                step();
            end
        end
        chk("d_done", {127'h0, if1.done}, {127'h0, 1'b1});
        chk("d_busy", {127'h0, if1.busy}, 128'h0);
        step();
        chk("d_done_pulse", {127'h0, if1.done}, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
